// File: rtl/axi_burst_read_master.sv
// AXI4 burst read initiator: takes one command, issues a single AR, streams
// the R beats downstream, checks each beat and reports completion status.
module axi_burst_read_master #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 8
) (
  input  logic                      axi_clk,
  input  logic                      axi_resetn,
  // command port
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic [1:0]                cmd_burst,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  // AR channel
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [7:0]                axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  // R channel
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready,
  // downstream stream
  output logic [AXI_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  // completion
  output logic                      done_valid,
  output logic                      done_error
);

  // Largest SIZE encoding that fits in one data beat.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic beat_done;
  logic beat_err;
  logic final_beat;

  // The AR payload is always the registered command, so it cannot change
  // while axi_ar_valid is waiting for axi_ar_ready.
  assign axi_ar_addr  = addr_q;
  assign axi_ar_len   = len_q;
  assign axi_ar_size  = size_q;
  assign axi_ar_burst = burst_q;
  assign axi_ar_id    = id_q;

  // A beat completes only when the downstream can take it; the counter
  // reaching zero or an R last (even an early one) ends the command.
  assign beat_done  = (state_q == DATA) && axi_r_valid && out_ready;
  assign final_beat = (cnt_q == 8'd0) || axi_r_last;
  assign beat_err   = (axi_r_resp != 2'b00) ||
                      (axi_r_id != id_q) ||
                      (axi_r_last && (cnt_q != 8'd0)) ||
                      (!axi_r_last && (cnt_q == 8'd0));

  // Next-state, datapath updates and Moore/pass-through outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    cmd_ready    = 1'b0;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    done_valid   = 1'b0;
    done_error   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          id_d    = cmd_id;
          cnt_d   = cmd_len;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        axi_ar_valid = 1'b1;
        // Oversized beats are flagged but the AR still goes out as given.
        if (size_q > MAX_SIZE) begin
          err_d = 1'b1;
        end
        if (axi_ar_ready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        axi_r_ready = out_ready;
        out_valid   = axi_r_valid;
        out_data    = axi_r_data;
        out_last    = final_beat;
        if (beat_done) begin
          if (beat_err) begin
            err_d = 1'b1;
          end
          if (final_beat) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      DONE: begin
        done_valid = 1'b1;
        done_error = err_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; reset abandons any in-flight transfer.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench for axi_burst_read_master: the bench plays the AXI responder
// and the downstream sink, all inputs change on the falling clock edge.
module tb_axi_burst_read_master;

  logic        axi_clk;
  logic        axi_resetn;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [7:0]  cmd_id;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] axi_ar_addr;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic [7:0]  axi_ar_id;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [63:0] axi_r_data;
  logic [7:0]  axi_r_id;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        done_valid;
  logic        done_error;

  int n_cmp = 0;
  int n_err = 0;

  axi_burst_read_master #(
    .AXI_ADDR_WIDTH(12),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH(8)
  ) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_id(cmd_id), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_ar_id(axi_ar_id), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_data(axi_r_data), .axi_r_id(axi_r_id), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready),
    .done_valid(done_valid), .done_error(done_error)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Present a command for one cycle; returns on the falling edge after acceptance.
  task automatic send_cmd(input logic [11:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b, input logic [7:0] i);
    @(negedge axi_clk);
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = i;
    cmd_valid = 1'b1;
    @(negedge axi_clk);
    cmd_valid = 1'b0;
  endtask

  // Accept the pending AR on the next rising edge.
  task automatic ar_handshake();
    axi_ar_ready = 1'b1;
    @(negedge axi_clk);
    axi_ar_ready = 1'b0;
  endtask

  // Drive one R beat and let the combinational outputs settle.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] i,
                            input logic [1:0] r, input logic l);
    axi_r_valid = 1'b1; axi_r_data = d; axi_r_id = i; axi_r_resp = r; axi_r_last = l;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    n_cmp++; if (axi_ar_valid !== 1'b0) begin n_err++; $display("FAIL reset_ar_valid: got %0b want 0", axi_ar_valid); end
    n_cmp++; if ({axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id} !== 33'd0) begin
      n_err++; $display("FAIL reset_ar_payload: got %0h want 0", {axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id}); end
    n_cmp++; if ({axi_r_ready, out_valid, out_last, done_valid, done_error} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl_outs: got %b want 00000", {axi_r_ready, out_valid, out_last, done_valid, done_error}); end
    n_cmp++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single();
    @(negedge axi_clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_cmd_ready: got %0b want 1", cmd_ready); end
    send_cmd(12'h010, 8'd0, 3'd3, 2'b01, 8'h05);
    n_cmp++; if (axi_ar_valid !== 1'b1) begin n_err++; $display("FAIL single_ar_valid: got %0b want 1", axi_ar_valid); end
    n_cmp++; if ({axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id} !== {12'h010, 8'd0, 3'd3, 2'b01, 8'h05}) begin
      n_err++; $display("FAIL single_ar_payload: got %0h want %0h", {axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id},
                        {12'h010, 8'd0, 3'd3, 2'b01, 8'h05}); end
    ar_handshake();
    n_cmp++; if (axi_ar_valid !== 1'b0) begin n_err++; $display("FAIL single_ar_drop: got %0b want 0", axi_ar_valid); end
    out_ready = 1'b1;
    drive_beat(64'h1122_3344_5566_7788, 8'h05, 2'b00, 1'b1);
    n_cmp++; if ({out_valid, out_last, axi_r_ready} !== 3'b111) begin
      n_err++; $display("FAIL single_beat_ctrl: got %b want 111", {out_valid, out_last, axi_r_ready}); end
    n_cmp++; if (out_data !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL single_beat_data: got %0h want 1122334455667788", out_data); end
    @(negedge axi_clk);
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
    n_cmp++; if ({done_valid, done_error} !== 2'b10) begin n_err++; $display("FAIL single_done: got %b want 10", {done_valid, done_error}); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL single_done_cmd_ready: got %0b want 0", cmd_ready); end
    @(negedge axi_clk);
    n_cmp++; if ({done_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL single_after_done: got %b want 01", {done_valid, cmd_ready}); end
    $display("single: len=0 burst complete");
  endtask

  task automatic test_incr8();
    int k = 0;
    int cyc = 0;
    send_cmd(12'h100, 8'd7, 3'd3, 2'b01, 8'h05);
    ar_handshake();
    while (k < 8 && cyc < 40) begin
      out_ready = (cyc % 2 == 1);
      drive_beat(64'hA000 + 64'(k), 8'h05, 2'b00, (k == 7));
      n_cmp++; if (axi_r_ready !== out_ready) begin n_err++; $display("FAIL incr_r_ready: got %0b want %0b", axi_r_ready, out_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL incr_out_valid: got %0b want 1", out_valid); end
      n_cmp++; if (out_data !== 64'hA000 + 64'(k)) begin n_err++; $display("FAIL incr_out_data: got %0h want %0h", out_data, 64'hA000 + 64'(k)); end
      n_cmp++; if (out_last !== (k == 7)) begin n_err++; $display("FAIL incr_out_last beat %0d: got %0b want %0b", k + 1, out_last, (k == 7)); end
      @(negedge axi_clk);
      if (out_ready) k++;
      cyc++;
    end
    axi_r_valid = 1'b0; axi_r_last = 1'b0; out_ready = 1'b0;
    n_cmp++; if (k !== 8) begin n_err++; $display("FAIL incr_beat_count: got %0d want 8", k); end
    n_cmp++; if ({done_valid, done_error} !== 2'b10) begin n_err++; $display("FAIL incr_done: got %b want 10", {done_valid, done_error}); end
    $display("incr8: %0d beats in %0d cycles", k, cyc);
  endtask

  task automatic test_ar_delay();
    send_cmd(12'h200, 8'd1, 3'd3, 2'b01, 8'h22);
    // Stray R traffic while the AR is pending must be ignored.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(64'hDEAD, 8'h22, 2'b00, 1'b0);
      n_cmp++; if ({axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id} !== {1'b1, 12'h200, 8'd1, 3'd3, 2'b01, 8'h22}) begin
        n_err++; $display("FAIL delay_ar_hold cycle %0d: got %0h want %0h", i,
                          {axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst, axi_ar_id},
                          {1'b1, 12'h200, 8'd1, 3'd3, 2'b01, 8'h22}); end
      n_cmp++; if ({axi_r_ready, out_valid} !== 2'b00) begin n_err++; $display("FAIL delay_r_blocked cycle %0d: got %b want 00", i, {axi_r_ready, out_valid}); end
      @(negedge axi_clk);
    end
    axi_r_valid = 1'b0;
    ar_handshake();
    for (int b = 0; b < 2; b++) begin
      drive_beat(64'hB0 + 64'(b), 8'h22, 2'b00, (b == 1));
      n_cmp++; if ({out_valid, out_last} !== {1'b1, (b == 1)}) begin
        n_err++; $display("FAIL delay_beat %0d: got %b want %b", b + 1, {out_valid, out_last}, {1'b1, (b == 1)}); end
      @(negedge axi_clk);
    end
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
    n_cmp++; if ({done_valid, done_error} !== 2'b10) begin n_err++; $display("FAIL delay_done: got %b want 10", {done_valid, done_error}); end
    $display("ar_delay: AR held 5 cycles then burst complete");
  endtask

  // kind 0: SLVERR on beat 2, 1: wrong id on beat 1, 2: early last on beat 2,
  // 3: missing last on beat 4. All with len=3.
  task automatic test_errors();
    for (int kind = 0; kind < 4; kind++) begin
      int nb = (kind == 2) ? 2 : 4;
      send_cmd(12'h300, 8'd3, 3'd3, 2'b01, 8'h05);
      ar_handshake();
      out_ready = 1'b1;
      for (int b = 1; b <= nb; b++) begin
        logic [1:0] rsp = (kind == 0 && b == 2) ? 2'b10 : 2'b00;
        logic [7:0] rid = (kind == 1 && b == 1) ? 8'h06 : 8'h05;
        logic       lst = (kind == 2) ? (b == 2) : (kind == 3) ? 1'b0 : (b == 4);
        drive_beat(64'hC00 + 64'(b), rid, rsp, lst);
        n_cmp++; if (out_last !== (b == nb)) begin
          n_err++; $display("FAIL err%0d_out_last beat %0d: got %0b want %0b", kind, b, out_last, (b == nb)); end
        @(negedge axi_clk);
      end
      axi_r_valid = 1'b0; axi_r_last = 1'b0;
      n_cmp++; if ({done_valid, done_error} !== 2'b11) begin n_err++; $display("FAIL err%0d_done: got %b want 11", kind, {done_valid, done_error}); end
      @(negedge axi_clk);
      n_cmp++; if ({done_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL err%0d_idle: got %b want 01", kind, {done_valid, cmd_ready}); end
      $display("errors: case %0d done after %0d beats", kind, nb);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(12'h400, 8'd15, 3'd3, 2'b01, 8'h07);
    ar_handshake();
    out_ready = 1'b1;
    for (int b = 1; b <= 2; b++) begin
      drive_beat(64'hD00 + 64'(b), 8'h07, 2'b00, 1'b0);
      @(negedge axi_clk);
    end
    drive_beat(64'hD03, 8'h07, 2'b00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_beat3_valid: got %0b want 1", out_valid); end
    axi_resetn = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_cmd_ready: got %0b want 1", cmd_ready); end
    n_cmp++; if ({axi_ar_valid, axi_r_ready, out_valid, out_last, done_valid, done_error} !== 6'b0) begin
      n_err++; $display("FAIL rstmid_ctrl: got %b want 000000", {axi_ar_valid, axi_r_ready, out_valid, out_last, done_valid, done_error}); end
    n_cmp++; if ({out_data, axi_ar_addr, axi_ar_len, axi_ar_id} !== 92'd0) begin
      n_err++; $display("FAIL rstmid_data: got %0h want 0", {out_data, axi_ar_addr, axi_ar_len, axi_ar_id}); end
    axi_r_valid = 1'b0;
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      n_cmp++; if ({done_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL rstmid_no_done %0d: got %b want 01", i, {done_valid, cmd_ready}); end
    end
    send_cmd(12'h040, 8'd0, 3'd3, 2'b01, 8'h09);
    ar_handshake();
    drive_beat(64'hE0, 8'h09, 2'b00, 1'b1);
    @(negedge axi_clk);
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
    n_cmp++; if ({done_valid, done_error} !== 2'b10) begin n_err++; $display("FAIL rstmid_recover_done: got %b want 10", {done_valid, done_error}); end
    $display("reset_mid: burst abandoned, new command completed");
  endtask

  task automatic test_size_err();
    send_cmd(12'h080, 8'd0, 3'd4, 2'b01, 8'h03);
    n_cmp++; if ({axi_ar_valid, axi_ar_size} !== {1'b1, 3'd4}) begin
      n_err++; $display("FAIL size_ar: got %b want 1100", {axi_ar_valid, axi_ar_size}); end
    ar_handshake();
    out_ready = 1'b1;
    drive_beat(64'hF0, 8'h03, 2'b00, 1'b1);
    @(negedge axi_clk);
    axi_r_valid = 1'b0; axi_r_last = 1'b0;
    n_cmp++; if ({done_valid, done_error} !== 2'b11) begin n_err++; $display("FAIL size_done: got %b want 11", {done_valid, done_error}); end
    $display("size_err: oversize AR issued, error reported");
  endtask

  initial begin
    axi_resetn = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0; cmd_id = '0; cmd_valid = 1'b0;
    axi_ar_ready = 1'b0;
    axi_r_data = '0; axi_r_id = '0; axi_r_resp = '0; axi_r_last = 1'b0; axi_r_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    @(negedge axi_clk);
    axi_resetn = 1'b1;
    test_single();
    test_incr8();
    test_ar_delay();
    test_errors();
    test_reset_mid();
    test_size_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
